// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } div_state_e;

    localparam logic [31:0] DIV0_QUOTIENT = '1;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a control FSM (master) and the divider (slave).
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    // The partial remainder is always below the divisor, so only the shifted value needs WIDTH+1 bits.
    logic [WIDTH:0] shifted;
    logic           fits;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs_i});
        rem_o   = fits ? WIDTH'(shifted - {1'b0, dvs_i}) : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], fits};
    end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
//
// state | meaning
// IDLE  | waiting for start, results held
// CALC  | iterating, one restoring step per cycle
// FIN   | done pulse, results valid; start here is accepted back-to-back
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_divider_if.slave bus
);
    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] dvs_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quotient_d;
    logic [WIDTH-1:0] remainder_d;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (acc_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic quo_neg_q;
    logic rem_neg_q;

    // Most-negative magnitude wraps to itself, which is still correct read as unsigned.
    assign dvd_mag     = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dvs_mag     = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    assign quotient_d  = quo_neg_q ? -step_quo : step_quo;
    assign remainder_d = rem_neg_q ? -step_rem : step_rem;
`else
    assign dvd_mag     = bus.dividend;
    assign dvs_mag     = bus.divisor;
    assign quotient_d  = step_quo;
    assign remainder_d = step_rem;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            dvs_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                CALC: begin
                    rem_q <= step_rem;
                    acc_q <= step_quo;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= FIN;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= quotient_d;
                        remainder_q <= remainder_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            state_q     <= FIN;
                            done_q      <= 1'b1;
                            quotient_q  <= DIV0_QUOTIENT[WIDTH-1:0];
                            remainder_q <= bus.dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_W'(WIDTH);
                            rem_q   <= '0;
                            acc_q   <= dvd_mag;
                            dvs_q   <= dvs_mag;
                            dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            quo_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            rem_neg_q <= bus.dividend[WIDTH-1];
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule
